// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_if
//  Description : Request/status bundle between a UART transmitter and its
//                client. The client (master) raises tx_start with a word on
//                data_in; the transmitter (slave) reports line state and
//                frame progress.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
    parameter int DBIT_WIDTH = 8
);
    logic                  tx_start;
    logic [DBIT_WIDTH-1:0] data_in;
    logic                  tx;
    logic                  tx_busy;
    logic                  tx_done_tick;

    modport master (
        output tx_start,
        output data_in,
        input  tx,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  data_in,
        output tx,
        output tx_busy,
        output tx_done_tick
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter. Serialises one DBIT_WIDTH-bit word into an
//                LSB-first frame (start, data, optional parity, stop), each
//                bit held for SB_TICK baud ticks. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DBIT_WIDTH = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY     = 0
) (
    input  wire       clk,
    input  wire       rst,
    input  wire       s_tick,
    uart_tx_if.slave  bus
);

    // Tick counter must hold SB_TICK-1 and is never narrower than 4 bits.
    localparam int c_SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int c_BW = $clog2(DBIT_WIDTH) + 1;

    localparam logic [c_SW-1:0] c_TICK_LAST = c_SW'(SB_TICK - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DBIT_WIDTH - 1);

    // Unsupported PARITY values fall back to "no parity".
    localparam logic c_PAR_EN = (PARITY == 1) || (PARITY == 2);
    localparam logic c_ODD    = (PARITY == 2);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_PAR   = 3'd3;
    localparam logic [2:0] c_STOP  = 3'd4;

    logic [2:0]            r_state;
    logic [c_SW-1:0]       r_s_reg;
    logic [c_BW-1:0]       r_n_reg;
    logic [DBIT_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_tick_last;
    logic                  w_parity_in;
    logic [DBIT_WIDTH-1:0] w_shift_next;

    assign w_tick_last  = (r_s_reg == c_TICK_LAST);
    assign w_parity_in  = (^bus.data_in) ^ c_ODD;
    assign w_shift_next = r_shift >> 1;

    // Frame sequencer; tx is loaded with the next bit value at the same edge
    // the state advances, so the line changes one clock after the tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_s_reg <= '0;
            r_n_reg <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_tx <= 1'b1;
                    if (bus.tx_start) begin
                        r_shift <= bus.data_in;
                        r_par   <= w_parity_in;
                        r_s_reg <= '0;
                        r_n_reg <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (s_tick) begin
                        if (w_tick_last) begin
                            r_s_reg <= '0;
                            r_tx    <= r_shift[0];
                            r_state <= c_DATA;
                        end else begin
                            r_s_reg <= r_s_reg + c_SW'(1);
                        end
                    end
                end
                c_DATA: begin
                    if (s_tick) begin
                        if (w_tick_last) begin
                            r_s_reg <= '0;
                            r_shift <= w_shift_next;
                            if (r_n_reg == c_BIT_LAST) begin
                                if (c_PAR_EN) begin
                                    r_tx    <= r_par;
                                    r_state <= c_PAR;
                                end else begin
                                    r_tx    <= 1'b1;
                                    r_state <= c_STOP;
                                end
                            end else begin
                                r_n_reg <= r_n_reg + c_BW'(1);
                                r_tx    <= w_shift_next[0];
                            end
                        end else begin
                            r_s_reg <= r_s_reg + c_SW'(1);
                        end
                    end
                end
                c_PAR: begin
                    if (s_tick) begin
                        if (w_tick_last) begin
                            r_s_reg <= '0;
                            r_tx    <= 1'b1;
                            r_state <= c_STOP;
                        end else begin
                            r_s_reg <= r_s_reg + c_SW'(1);
                        end
                    end
                end
                c_STOP: begin
                    if (s_tick) begin
                        if (w_tick_last) begin
                            r_s_reg <= '0;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_s_reg <= r_s_reg + c_SW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_s_reg <= '0;
                    r_n_reg <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx           = r_tx;
    assign bus.tx_busy      = r_busy;
    assign bus.tx_done_tick = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx. Four instances with
//                different widths/tick counts/parity share one stimulus;
//                each has a frame-list reference model compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int c_N = 4;

    logic        clk;
    logic        rst;
    logic        s_tick;
    logic        tx_start;
    logic [15:0] data_bus;

    logic [c_N-1:0] act_tx, act_busy, act_done;
    logic [c_N-1:0] exp_tx, exp_busy, exp_done;

    int  checks   = 0;
    int  failures = 0;
    bit  cmp_en   = 1'b0;
    int  tick_mode = 0;
    int  cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instances: 0 = 8N1/16, 1 = 8E1/16, 2 = 8O1/16, 3 = 7N1/8
    for (genvar i = 0; i < c_N; i++) begin : g_dut
        localparam int DW  = (i == 3) ? 7 : 8;
        localparam int SB  = (i == 3) ? 8 : 16;
        localparam int PAR = (i == 1) ? 1 : ((i == 2) ? 2 : 0);

        uart_tx_if #(.DBIT_WIDTH(DW)) bus ();

        assign bus.tx_start = tx_start;
        assign bus.data_in  = data_bus[DW-1:0];
        assign act_tx[i]    = bus.tx;
        assign act_busy[i]  = bus.tx_busy;
        assign act_done[i]  = bus.tx_done_tick;

        uart_tx #(.DBIT_WIDTH(DW), .SB_TICK(SB), .PARITY(PAR)) dut (
            .clk    (clk),
            .rst    (rst),
            .s_tick (s_tick),
            .bus    (bus)
        );

        // Reference: a frame is a list of line levels, each held SB ticks.
        logic m_tx, m_busy, m_done;
        logic m_frame [0:19];
        int   m_idx, m_ticks, m_nbits;

        assign exp_tx[i]   = m_tx;
        assign exp_busy[i] = m_busy;
        assign exp_done[i] = m_done;

        initial begin
            m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0;
            m_idx = 0; m_ticks = 0; m_nbits = 0;
            forever begin
                @(posedge clk);
                m_done = 1'b0;
                if (!rst) begin
                    m_busy = 1'b0;
                    m_tx   = 1'b1;
                end else if (!m_busy) begin
                    if (tx_start) begin
                        int n;
                        m_frame[0] = 1'b0;
                        for (int b = 0; b < DW; b++) m_frame[1+b] = data_bus[b];
                        n = 1 + DW;
                        if (PAR != 0) begin
                            m_frame[n] = (($countones(data_bus[DW-1:0]) % 2) == 1) ^ (PAR == 2);
                            n++;
                        end
                        m_frame[n] = 1'b1;
                        m_nbits = n + 1;
                        m_busy = 1'b1; m_idx = 0; m_ticks = 0; m_tx = 1'b0;
                    end
                end else if (s_tick) begin
                    m_ticks++;
                    if (m_ticks == SB) begin
                        m_ticks = 0;
                        m_idx++;
                        if (m_idx == m_nbits) begin
                            m_busy = 1'b0; m_tx = 1'b1; m_done = 1'b1;
                        end else begin
                            m_tx = m_frame[m_idx];
                        end
                    end
                end
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick source: every cycle, every 4th cycle, or random.
    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            case (tick_mode)
                0:       s_tick = 1'b1;
                1:       s_tick = (cyc % 4 == 0);
                default: s_tick = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Cycle-by-cycle comparison of every instance against its model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int k = 0; k < c_N; k++) begin
                    check($sformatf("tx[%0d]", k),   act_tx[k],   exp_tx[k]);
                    check($sformatf("busy[%0d]", k), act_busy[k], exp_busy[k]);
                    check($sformatf("done[%0d]", k), act_done[k], exp_done[k]);
                end
            end
        end
    end

    task automatic send(input logic [15:0] d);
        @(negedge clk);
        tx_start = 1'b1;
        data_bus = d;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Called at the first negedge after acceptance: samples mid-bit levels and
    // returns the cycle offset at which tx_done_tick is seen.
    task automatic run_frame(input int k, input int sb, input int nbits,
                             output logic [15:0] bits, output int len);
        bits = '0;
        len  = -1;
        for (int c = 0; c < 4000; c++) begin
            if ((c % sb) == (sb / 2) && (c / sb) < nbits) bits[c/sb] = act_tx[k];
            if (act_done[k]) begin
                len = c;
                break;
            end
            @(negedge clk);
        end
        if (len < 0) check($sformatf("frame_timeout[%0d]", k), act_done[k], 1);
    endtask

    task automatic wait_idle();
        int c;
        for (c = 0; c < 20000; c++) begin
            if (act_busy == '0) break;
            @(negedge clk);
        end
        if (c >= 20000) check("idle_timeout", act_busy, 0);
    endtask

    task automatic wait_done(input int k);
        int c;
        for (c = 0; c < 5000; c++) begin
            if (act_done[k]) break;
            @(negedge clk);
        end
        if (c >= 5000) check($sformatf("done_timeout[%0d]", k), act_done[k], 1);
    endtask

    initial begin
        logic [15:0] bits;
        int          len;
        int          run;

        rst = 1'b0; tx_start = 1'b0; data_bus = '0;
        repeat (3) @(negedge clk);
        check("reset_tx",   act_tx,   4'hF);
        check("reset_busy", act_busy, 4'h0);
        check("reset_done", act_done, 4'h0);
        rst = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA5, 8N1, tick every cycle
        tick_mode = 0;
        send(16'h00A5);
        run_frame(0, 16, 10, bits, len);
        check("a5_bits", bits[9:0], 10'b1101001010);
        check("a5_len",  len, 160);
        wait_idle();

        // 0x07 with even parity, then odd parity
        send(16'h0007);
        run_frame(1, 16, 11, bits, len);
        check("even_par_bit", bits[9], 1'b1);
        check("even_len", len, 176);
        wait_idle();
        send(16'h0007);
        run_frame(2, 16, 11, bits, len);
        check("odd_par_bit", bits[9], 1'b0);
        check("odd_len", len, 176);
        wait_idle();

        // 7-bit, SB_TICK=8: 0x7F
        send(16'h007F);
        run_frame(3, 8, 9, bits, len);
        check("w7_bits", bits[8:0], 9'b111111110);
        check("w7_len", len, 72);
        wait_idle();

        // Slow ticks, 0x3C, with a stray start request and new data mid-frame
        tick_mode = 1;
        repeat (2) @(negedge clk);
        send(16'h003C);
        repeat (100) @(negedge clk);
        tx_start = 1'b1; data_bus = 16'h00FF;
        @(negedge clk);
        tx_start = 1'b0;
        for (int c = 0; c < 2000 && act_tx[0] == 1'b0; c++) @(negedge clk);
        run = 0;
        for (int c = 0; c < 2000 && act_tx[0] == 1'b1; c++) begin
            run++;
            @(negedge clk);
        end
        check("slow_run_4bits", run, 256);
        wait_idle();
        repeat (200) @(negedge clk);
        check("no_second_frame", act_busy[0], 1'b0);

        // Back-to-back with tx_start held
        tick_mode = 0;
        @(negedge clk);
        tx_start = 1'b1; data_bus = 16'h0001;
        @(negedge clk);
        data_bus = 16'h0080;
        wait_done(0);
        check("b2b_gap_tx",   act_tx[0],   1'b1);
        check("b2b_gap_busy", act_busy[0], 1'b0);
        @(negedge clk);
        check("b2b_restart_tx",   act_tx[0],   1'b0);
        check("b2b_restart_busy", act_busy[0], 1'b1);
        tx_start = 1'b0;
        wait_done(0);
        check("b2b_second_done", act_done[0], 1'b1);
        wait_idle();

        // Reset in the middle of the data bits
        send(16'h0055);
        repeat (60) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_tx",   act_tx,   4'hF);
        check("midrst_busy", act_busy, 4'h0);
        check("midrst_done", act_done, 4'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send(16'h0055);
        run_frame(0, 16, 10, bits, len);
        check("post_rst_bits", bits[9:0], 10'b1010101010);
        check("post_rst_len", len, 160);
        wait_idle();

        // Randomised traffic
        tick_mode = 2;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            tx_start = ($urandom_range(0, 9) == 0);
            data_bus = 16'($urandom);
            rst      = ($urandom_range(0, 999) != 0);
        end
        tx_start = 1'b0;
        rst = 1'b1;
        wait_idle();
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one DBIT_WIDTH-bit word per request into an LSB-first frame of start bit, data bits, optional parity bit and stop bit on `tx`. It is the transmit half of the UART core and shares the baud generator's `s_tick` with `uart_rx`. Each bit is held for SB_TICK ticks, so with matching parameters its frames are bit-compatible with `uart_rx`.

## Interface
- DBIT_WIDTH, 8: data bits per frame (1..16).
- SB_TICK, 16: `s_tick` count per bit period; applies to start, data, parity and stop bits alike.
- PARITY, 0: 0 = none, 1 = even, 2 = odd. Other values are illegal and must be treated as 0.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- s_tick  input  1  one-cycle baud/oversample tick from the baud generator.
- tx_start  input  1  transmit request; sampled only in IDLE.
- data_in  input  DBIT_WIDTH  word to send; captured on the accepting cycle.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high while a frame is in progress (state != IDLE).
- tx_done_tick  output  1  one-cycle pulse at the end of the stop bit.

## Operation
- States: IDLE, START, DATA, PAR, STOP. Registers: tick counter `s_reg` (4+ bits, enough for SB_TICK-1), bit counter (clog2(DBIT_WIDTH)+1 bits), shift register (DBIT_WIDTH), parity bit, `tx` register.
- IDLE: `tx`=1. If `tx_start`=1, capture `data_in` into the shift register, compute parity from `data_in` (even: XOR of bits; odd: inverted XOR), clear `s_reg` and the bit counter, then go to START.
- START: `tx`=0. On each `s_tick`, increment `s_reg`. On the `s_tick` with `s_reg`==SB_TICK-1, clear `s_reg` and go to DATA.
- DATA: `tx`=shift[0]. On the `s_tick` with `s_reg`==SB_TICK-1, clear `s_reg` and shift right by one. If the bit counter is DBIT_WIDTH-1, go to PAR (PARITY!=0) or STOP. Otherwise increment the bit counter.
- PAR: `tx`=parity bit. It lasts SB_TICK ticks, then goes to STOP.
- STOP: `tx`=1. On the `s_tick` with `s_reg`==SB_TICK-1, go to IDLE and pulse `tx_done_tick`.
- `s_tick` is ignored in IDLE. Between ticks, all counters hold.
- An illegal state recovers to IDLE with `tx`=1 and counters cleared.

## Timing
- Reset (`rst`=0 at a clock edge): next cycle has state IDLE, `tx`=1, `tx_busy`=0, `tx_done_tick`=0, and counters and shift register at 0. Reset applies mid-frame with no completion pulse.
- Start latency: `tx_start` is high at edge N; `tx` is 0 and `tx_busy` is 1 from edge N+1.
- An `s_tick` coincident with the accepting cycle is not counted. The start bit spans exactly SB_TICK subsequent ticks.
- Every `tx` transition occurs one clock after the qualifying `s_tick` (registered output).
- Frame length is SB_TICK × (2 + DBIT_WIDTH + (PARITY?1:0)) ticks.
- `tx_done_tick`, the return to IDLE and `tx_busy`=0 all occur at the same edge after the final stop tick. `tx_done_tick` lasts exactly one cycle.
- Back-to-back: `tx_start` held high is accepted in the first IDLE cycle, i.e. the cycle after `tx_done_tick`. `tx` stays 1 for that single cycle only.
- `tx_start` while busy is ignored and not queued. `data_in` changes after acceptance do not affect the frame.

## Test plan
- DBIT_WIDTH=8, SB_TICK=16, PARITY=0, `s_tick` every cycle, send 0xA5:
  - `tx` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles.
  - `tx_done_tick` occurs once, 160 ticks after the start bit.
  - A `uart_rx` loopback reports 0xA5.
- PARITY=1 with 0x07: the parity bit is 1. PARITY=2 with 0x07: the parity bit is 0. Frame length is 176 ticks.
- `s_tick` every 4 cycles, send 0x3C:
  - Each bit lasts 64 cycles.
  - Inserting a `tx_start` pulse and changing `data_in` to 0xFF mid-frame leaves the output unchanged.
  - No second frame follows.
- `tx_start` held high with 0x01 then 0x80: two contiguous frames, a single idle-high cycle between them, and two `tx_done_tick` pulses.
- `rst`=0 during the DATA state of 0x55: next cycle `tx`=1, `tx_busy`=0, and no `tx_done_tick`. A following transmit of 0x55 is correct.
- DBIT_WIDTH=7, SB_TICK=8: send 0x7F. Frame is 0 + seven 1s + 1, 72 ticks total.
